blocking_and_nonblocking: RTL and testbench



---
 rtl/blocking_and_nonblocking.sv | 132 +++++++++++++
 tb/tb_blocking_and_nonblocking.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/blocking_and_nonblocking.sv
// blocking_and_nonblocking: a free-running counter drives two 3-stage chains.
// The nonblocking chain (nb_a -> nb_b -> nb_c) is a true 3-deep pipeline.
// The blocking chain (bl_a = cnt; bl_b = bl_a; bl_c = bl_b) collapses so that
// every stage holds the pre-edge counter value, i.e. a single register.
// diff = bl_c - nb_c (mod 2^WIDTH); pipe_full rises once the pipeline holds
// three samples since reset.
// Optional feature macro: BNB_SWAP_EN adds the nb_x/nb_y and bl_x/bl_y swap
// pair registers and ports.
module blocking_and_nonblocking #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] nb_a,
  output logic [WIDTH-1:0] nb_b,
  output logic [WIDTH-1:0] nb_c,
  output logic [WIDTH-1:0] bl_c,
  output logic [WIDTH-1:0] diff,
`ifdef BNB_SWAP_EN
  output logic             pipe_full,
  output logic             nb_x,
  output logic             nb_y,
  output logic             bl_x,
  output logic             bl_y
`else
  output logic             pipe_full
`endif
);

  logic [WIDTH-1:0] cnt_q,  cnt_d;
  logic [WIDTH-1:0] nb_a_q, nb_a_d;
  logic [WIDTH-1:0] nb_b_q, nb_b_d;
  logic [WIDTH-1:0] nb_c_q, nb_c_d;
  logic [WIDTH-1:0] bl_a_d;
  logic [WIDTH-1:0] bl_b_d;
  logic [WIDTH-1:0] bl_c_q, bl_c_d;
  logic [1:0]       fill_q, fill_d;

  // Free-running stimulus counter, wraps naturally at 2^WIDTH.
  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
  end

  // Nonblocking chain: each stage reads the previous stage's pre-edge value.
  always_comb begin
    nb_a_d = cnt_q;
    nb_b_d = nb_a_q;
    nb_c_d = nb_b_q;
  end

  // Blocking chain: each stage reads the value just assigned above it, so all
  // three collapse to the pre-edge counter. bl_a and bl_b always equal bl_c
  // after the edge, so only the final stage needs storage.
  always_comb begin
    bl_a_d = cnt_q;
    bl_b_d = bl_a_d;
    bl_c_d = bl_b_d;
  end

  // Fill counter saturates at 3, marking a pipeline full of valid samples.
  always_comb begin
    if (fill_q == 2'd3) begin
      fill_d = fill_q;
    end else begin
      fill_d = fill_q + 2'd1;
    end
  end

  // Main state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      nb_a_q <= '0;
      nb_b_q <= '0;
      nb_c_q <= '0;
      bl_c_q <= '0;
      fill_q <= 2'd0;
    end else begin
      cnt_q  <= cnt_d;
      nb_a_q <= nb_a_d;
      nb_b_q <= nb_b_d;
      nb_c_q <= nb_c_d;
      bl_c_q <= bl_c_d;
      fill_q <= fill_d;
    end
  end

  assign cnt       = cnt_q;
  assign nb_a      = nb_a_q;
  assign nb_b      = nb_b_q;
  assign nb_c      = nb_c_q;
  assign bl_c      = bl_c_q;
  assign diff      = bl_c_q - nb_c_q;
  assign pipe_full = (fill_q == 2'd3);

`ifdef BNB_SWAP_EN
  logic nb_x_q, nb_x_d;
  logic nb_y_q, nb_y_d;
  logic bl_x_q, bl_x_d;
  logic bl_y_q, bl_y_d;

  // Swap pairs: nonblocking really swaps, blocking copies old bl_y into both.
  always_comb begin
    nb_x_d = nb_y_q;
    nb_y_d = nb_x_q;
    bl_x_d = bl_y_q;
    bl_y_d = bl_x_d;
  end

  // Swap pair registers with synchronous reset to (1,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      nb_x_q <= 1'b1;
      nb_y_q <= 1'b0;
      bl_x_q <= 1'b1;
      bl_y_q <= 1'b0;
    end else begin
      nb_x_q <= nb_x_d;
      nb_y_q <= nb_y_d;
      bl_x_q <= bl_x_d;
      bl_y_q <= bl_y_d;
    end
  end

  assign nb_x = nb_x_q;
  assign nb_y = nb_y_q;
  assign bl_x = bl_x_q;
  assign bl_y = bl_y_q;
`endif

endmodule

// File: tb/tb_blocking_and_nonblocking.sv
// Directed testbench for blocking_and_nonblocking (WIDTH = 8).
// Build with BNB_SWAP_EN defined to also exercise the swap pair.
module tb_blocking_and_nonblocking;

  logic       clk;
  logic       reset;
  logic [7:0] cnt;
  logic [7:0] nb_a;
  logic [7:0] nb_b;
  logic [7:0] nb_c;
  logic [7:0] bl_c;
  logic [7:0] diff;
  logic       pipe_full;
`ifdef BNB_SWAP_EN
  logic       nb_x;
  logic       nb_y;
  logic       bl_x;
  logic       bl_y;
`endif

  int checks = 0;
  int errors = 0;

  blocking_and_nonblocking #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cnt       (cnt),
    .nb_a      (nb_a),
    .nb_b      (nb_b),
    .nb_c      (nb_c),
    .bl_c      (bl_c),
    .diff      (diff),
`ifdef BNB_SWAP_EN
    .pipe_full (pipe_full),
    .nb_x      (nb_x),
    .nb_y      (nb_y),
    .bl_x      (bl_x),
    .bl_y      (bl_y)
`else
    .pipe_full (pipe_full)
`endif
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Let n rising edges pass, then return on the following falling edge.
  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    @(negedge clk);
  endtask

  // Hold reset for two edges and check every output at its reset value.
  task automatic test_reset();
    reset = 1'b1;
    advance(2);
    checks++;
    if (cnt !== 8'd0 || nb_a !== 8'd0 || nb_b !== 8'd0 || nb_c !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_cnt_nb got cnt=%0d nb=%0d/%0d/%0d want 0/0/0/0", cnt, nb_a, nb_b, nb_c);
    end
    checks++;
    if (bl_c !== 8'd0 || diff !== 8'd0 || pipe_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_bl_diff got bl_c=%0d diff=%0d full=%0b want 0/0/0", bl_c, diff, pipe_full);
    end
`ifdef BNB_SWAP_EN
    checks++;
    if ({nb_x, nb_y, bl_x, bl_y} !== 4'b1010) begin
      errors++;
      $display("[TB] FAIL reset_swap got %b want 1010", {nb_x, nb_y, bl_x, bl_y});
    end
`endif
    reset = 1'b0;
  endtask

  // Step through k=1..5 checking fill behaviour and the chains.
  task automatic test_chains();
    advance(1);
    checks++;
    if (cnt !== 8'd1 || nb_a !== 8'd0 || bl_c !== 8'd0 || diff !== 8'd0 || pipe_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL k1 got cnt=%0d nb_a=%0d bl_c=%0d diff=%0d full=%0b want 1/0/0/0/0",
               cnt, nb_a, bl_c, diff, pipe_full);
    end
    advance(1);
    checks++;
    if (cnt !== 8'd2 || bl_c !== 8'd1 || nb_c !== 8'd0 || diff !== 8'd1 || pipe_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL k2 got cnt=%0d bl_c=%0d nb_c=%0d diff=%0d full=%0b want 2/1/0/1/0",
               cnt, bl_c, nb_c, diff, pipe_full);
    end
    advance(1);
    checks++;
    if (bl_c !== 8'd2 || nb_c !== 8'd0 || diff !== 8'd2 || pipe_full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL k3 got bl_c=%0d nb_c=%0d diff=%0d full=%0b want 2/0/2/1",
               bl_c, nb_c, diff, pipe_full);
    end
    advance(2);
    checks++;
    if (cnt !== 8'd5 || nb_a !== 8'd4 || nb_b !== 8'd3 || nb_c !== 8'd2) begin
      errors++;
      $display("[TB] FAIL k5_nb got cnt=%0d nb=%0d/%0d/%0d want 5/4/3/2", cnt, nb_a, nb_b, nb_c);
    end
    checks++;
    if (bl_c !== 8'd4 || diff !== 8'd2 || pipe_full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL k5_bl got bl_c=%0d diff=%0d full=%0b want 4/2/1", bl_c, diff, pipe_full);
    end
  endtask

  // Continue from k=5 to k=257 checking diff every edge and the wrap point.
  task automatic test_wrap();
    int bad_diff;
    bad_diff = 0;
    for (int k = 6; k <= 257; k++) begin
      advance(1);
      if (diff !== 8'd2 || pipe_full !== 1'b1) begin
        bad_diff++;
        if (bad_diff == 1) begin
          $display("[TB] FAIL wrap_diff at k=%0d got diff=%0d full=%0b want 2/1", k, diff, pipe_full);
        end
      end
    end
    checks++;
    if (bad_diff != 0) begin
      errors++;
    end
    checks++;
    if (cnt !== 8'd1 || bl_c !== 8'd0 || nb_c !== 8'd254 || diff !== 8'd2) begin
      errors++;
      $display("[TB] FAIL k257 got cnt=%0d bl_c=%0d nb_c=%0d diff=%0d want 1/0/254/2",
               cnt, bl_c, nb_c, diff);
    end
    checks++;
    if (nb_a !== 8'd0 || nb_b !== 8'd255) begin
      errors++;
      $display("[TB] FAIL k257_nb got nb_a=%0d nb_b=%0d want 0/255", nb_a, nb_b);
    end
  endtask

  // Reset, run to k=10, pulse reset for one edge, then check the restart.
  task automatic test_mid_reset();
    reset = 1'b1;
    advance(1);
    reset = 1'b0;
    advance(10);
    checks++;
    if (cnt !== 8'd10 || nb_c !== 8'd7 || bl_c !== 8'd9 || pipe_full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL k10 got cnt=%0d nb_c=%0d bl_c=%0d full=%0b want 10/7/9/1",
               cnt, nb_c, bl_c, pipe_full);
    end
    reset = 1'b1;
    advance(1);
    checks++;
    if (cnt !== 8'd0 || nb_a !== 8'd0 || nb_b !== 8'd0 || nb_c !== 8'd0 ||
        bl_c !== 8'd0 || diff !== 8'd0 || pipe_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset got cnt=%0d nb=%0d/%0d/%0d bl_c=%0d diff=%0d full=%0b want all 0",
               cnt, nb_a, nb_b, nb_c, bl_c, diff, pipe_full);
    end
    reset = 1'b0;
    advance(2);
    checks++;
    if (cnt !== 8'd2 || diff !== 8'd1 || pipe_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_k2 got cnt=%0d diff=%0d full=%0b want 2/1/0", cnt, diff, pipe_full);
    end
  endtask

`ifdef BNB_SWAP_EN
  // Swap pair over four edges after reset.
  task automatic test_swap();
    logic [1:0] nb_exp [4];
    nb_exp[0] = 2'b01;
    nb_exp[1] = 2'b10;
    nb_exp[2] = 2'b01;
    nb_exp[3] = 2'b10;
    reset = 1'b1;
    advance(1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      advance(1);
      checks++;
      if ({nb_x, nb_y} !== nb_exp[i] || {bl_x, bl_y} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL swap_edge%0d got nb=%b bl=%b want nb=%b bl=00",
                 i + 1, {nb_x, nb_y}, {bl_x, bl_y}, nb_exp[i]);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    test_reset();
    test_chains();
    test_wrap();
    test_mid_reset();
`ifdef BNB_SWAP_EN
    test_swap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout reached without completing the sequence");
    $fatal(1, "[TB] timeout");
  end

endmodule
